// File: rtl/vga_video_out.sv
// rtl/vga_video_out.sv - parametrised VGA timing generator and latency-aligned output stage
module vga_video_out #(
    parameter int RGB_WIDTH = 8,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIX_LAT   = 2,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 pix_req,
    output logic [HW-1:0]        pix_x,
    output logic [VW-1:0]        pix_y,
    output logic                 frame_start,
    input  logic [RGB_WIDTH-1:0] rgb_in_r,
    input  logic [RGB_WIDTH-1:0] rgb_in_g,
    input  logic [RGB_WIDTH-1:0] rgb_in_b,
    output logic [RGB_WIDTH-1:0] vga_r,
    output logic [RGB_WIDTH-1:0] vga_g,
    output logic [RGB_WIDTH-1:0] vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_blank_n
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hs_raw, vs_raw, vis_raw;
    logic [2:0]    raw_terms, dly_terms;

    logic [RGB_WIDTH-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
    logic                 vga_hsync_q, vga_hsync_d;
    logic                 vga_vsync_q, vga_vsync_d;
    logic                 vga_blank_n_q, vga_blank_n_d;

    // Next-state of the raster counters: cleared while disabled, h wraps and carries into v
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (int'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    // Raster counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Raw timing terms; all forced inactive while disabled so the pins blank cleanly
    always_comb begin
        vis_raw   = en && (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_raw    = en && (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
        vs_raw    = en && (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);
        raw_terms = {hs_raw, vs_raw, vis_raw};
    end

    assign pix_req     = vis_raw;
    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign frame_start = en && (h_cnt_q == '0) && (v_cnt_q == '0);

    // Delay line matching the pixel source's read latency (bypassed when it is zero)
    generate
        if (PIX_LAT == 0) begin : g_no_dly
            assign dly_terms = raw_terms;
        end else begin : g_dly
            logic [2:0] pipe_q [PIX_LAT];
            logic [2:0] pipe_d [PIX_LAT];

            // Shift the timing terms one stage per pixel
            always_comb begin
                pipe_d[0] = raw_terms;
                for (int i = 1; i < PIX_LAT; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Delay line registers, cleared to inactive terms
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign dly_terms = pipe_q[PIX_LAT-1];
        end
    endgenerate

    // Pin values: polarity applied to syncs, colour captured only on visible pixels
    always_comb begin
        vga_hsync_d   = dly_terms[2] ? HS_POL : ~HS_POL;
        vga_vsync_d   = dly_terms[1] ? VS_POL : ~VS_POL;
        vga_blank_n_d = dly_terms[0];
        vga_r_d       = dly_terms[0] ? rgb_in_r : '0;
        vga_g_d       = dly_terms[0] ? rgb_in_g : '0;
        vga_b_d       = dly_terms[0] ? rgb_in_b : '0;
    end

    // Output pin registers, reset to idle sync levels and black
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hsync_q   <= ~HS_POL;
            vga_vsync_q   <= ~VS_POL;
            vga_blank_n_q <= 1'b0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
        end else begin
            vga_hsync_q   <= vga_hsync_d;
            vga_vsync_q   <= vga_vsync_d;
            vga_blank_n_q <= vga_blank_n_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
        end
    end

    assign vga_hsync   = vga_hsync_q;
    assign vga_vsync   = vga_vsync_q;
    assign vga_blank_n = vga_blank_n_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_video_out.sv
// tb/tb_vga_video_out.sv - scoreboard bench for vga_video_out on a small raster
module tb_vga_video_out;

    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam int LAT = 2, W = 8, W2 = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);

    typedef struct { int due; bit hs; bit vs; bit bl; logic [W-1:0] r; logic [W-1:0] g; logic [W-1:0] b; } pin_t;
    typedef struct { int at; bit req; int x; int y; bit fs; } src_t;
    typedef struct { logic [W-1:0] r; logic [W-1:0] g; logic [W-1:0] b; } rgb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic [W-1:0] rin = '1, gin = '1, bin = '1;
    logic [W2-1:0] f4 = 4'hF;

    logic pix_req, frame_start, hsync, vsync, blank_n;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [W-1:0] vr, vg, vb;

    logic pix_req2, frame_start2, hsync2, vsync2, blank_n2;
    logic [XW-1:0] pix_x2;
    logic [YW-1:0] pix_y2;
    logic [W2-1:0] vr2, vg2, vb2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pos = 0;
    bit fresh = 1'b1;

    pin_t pin_q[$];
    src_t src_q[$];
    rgb_t data_q[$];
    pin_t mp;
    src_t ms;

    vga_video_out #(
        .RGB_WIDTH(W), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .rgb_in_r(rin), .rgb_in_g(gin), .rgb_in_b(bin),
        .vga_r(vr), .vga_g(vg), .vga_b(vb),
        .vga_hsync(hsync), .vga_vsync(vsync), .vga_blank_n(blank_n)
    );

    vga_video_out #(
        .RGB_WIDTH(W2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_LAT(LAT)
    ) dut_pol (
        .clk(clk), .rst(rst), .en(en),
        .pix_req(pix_req2), .pix_x(pix_x2), .pix_y(pix_y2), .frame_start(frame_start2),
        .rgb_in_r(f4), .rgb_in_g(f4), .rgb_in_b(f4),
        .vga_r(vr2), .vga_g(vg2), .vga_b(vb2),
        .vga_hsync(hsync2), .vga_vsync(vsync2), .vga_blank_n(blank_n2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, " hsync"}, 32'(hsync), 32'd1);
        chk({tag, " vsync"}, 32'(vsync), 32'd1);
        chk({tag, " blank_n"}, 32'(blank_n), 32'd0);
        chk({tag, " rgb"}, {8'd0, vr, vg, vb}, 32'd0);
        chk({tag, " hsync_pol"}, 32'(hsync2), 32'd0);
        chk({tag, " vsync_pol"}, 32'(vsync2), 32'd0);
        chk({tag, " r_pol"}, 32'(vr2), 32'd0);
    endtask

    // Source model state after reset: raster origin, latency line filled with junk
    task automatic model_init();
        rgb_t junk;
        junk.r = '1; junk.g = '1; junk.b = '1;
        pos = 0;
        fresh = 1'b1;
        data_q.delete();
        for (int i = 0; i < LAT; i++) data_q.push_back(junk);
    endtask

    // One pixel clock: drive inputs, predict source outputs now and pins LAT+1 later
    task automatic do_cycle(input bit en_v);
        int h, v;
        bit vis, hs, vs;
        rgb_t nxt, cur;
        pin_t p;
        src_t s;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = en_v;
        if (fresh) begin
            for (int d = 0; d <= LAT; d++) begin
                p.due = cyc + d; p.hs = 0; p.vs = 0; p.bl = 0; p.r = '0; p.g = '0; p.b = '0;
                pin_q.push_back(p);
            end
            fresh = 1'b0;
        end
        h = pos % HT;
        v = pos / HT;
        vis = en_v && (h < HA) && (v < VA);
        hs  = en_v && (h >= HA + HF) && (h < HA + HF + HSW);
        vs  = en_v && (v >= VA + VF) && (v < VA + VF + VSW);
        s.at = cyc; s.req = vis; s.x = h; s.y = v; s.fs = en_v && (pos == 0);
        src_q.push_back(s);
        if (vis) begin
            nxt.r = W'($urandom); nxt.g = W'($urandom); nxt.b = W'($urandom);
        end else begin
            nxt.r = '1; nxt.g = '1; nxt.b = '1;
        end
        data_q.push_back(nxt);
        cur = data_q.pop_front();
        rin = cur.r; gin = cur.g; bin = cur.b;
        p.due = cyc + LAT + 1; p.hs = hs; p.vs = vs; p.bl = vis;
        p.r = vis ? nxt.r : '0; p.g = vis ? nxt.g : '0; p.b = vis ? nxt.b : '0;
        pin_q.push_back(p);
        pos = en_v ? (pos + 1) % FT : 0;
    endtask

    // Asynchronous reset between edges; pins must snap to idle immediately
    task automatic pulse_reset(input int hold);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_pins("async_rst");
        pin_q.delete();
        src_q.delete();
        model_init();
        repeat (hold) @(posedge clk);
    endtask

    // Monitor: compare whatever the model expects for this cycle
    always @(negedge clk) begin
        if (src_q.size() > 0 && src_q[0].at == cyc) begin
            ms = src_q.pop_front();
            chk("pix_req", 32'(pix_req), 32'(ms.req));
            chk("pix_x", 32'(pix_x), ms.x);
            chk("pix_y", 32'(pix_y), ms.y);
            chk("frame_start", 32'(frame_start), 32'(ms.fs));
        end
        while (pin_q.size() > 0 && pin_q[0].due == cyc) begin
            mp = pin_q.pop_front();
            chk("hsync", 32'(hsync), 32'(!mp.hs));
            chk("vsync", 32'(vsync), 32'(!mp.vs));
            chk("blank_n", 32'(blank_n), 32'(mp.bl));
            chk("rgb", {8'd0, vr, vg, vb}, {8'd0, mp.r, mp.g, mp.b});
            chk("hsync_pol", 32'(hsync2), 32'(mp.hs));
            chk("vsync_pol", 32'(vsync2), 32'(mp.vs));
            chk("blank_n_pol", 32'(blank_n2), 32'(mp.bl));
            chk("r_pol", 32'(vr2), mp.bl ? 32'hF : 32'h0);
        end
    end

    initial begin
        model_init();
        repeat (3) @(posedge clk);
        #2;
        check_reset_pins("reset_hold");

        repeat (2 * FT) do_cycle(1'b1);

        while (pos != HT * 1 + 2) do_cycle(1'b1);
        repeat (5) do_cycle(1'b0);
        repeat (FT + 3) do_cycle(1'b1);

        while (pos != HT * 2 + 3) do_cycle(1'b1);
        do_cycle(1'b1);
        pulse_reset(2);
        repeat (FT + 5) do_cycle(1'b1);

        repeat (500) begin
            if ($urandom_range(0, 99) < 2) pulse_reset(int'($urandom_range(0, 3)));
            do_cycle($urandom_range(0, 15) != 0);
        end

        repeat (LAT + 3) do_cycle(1'b1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
